// File: rtl/mul.sv
// Iterative radix-2 shift-add 32x32->64 multiplier with per-operand signedness.
// Magnitudes are multiplied unsigned; the sign is applied once in the finish cycle.
//
// state   | meaning
// ST_IDLE | no operation in flight; results hold
// ST_RUN  | count!=0: add/shift iteration; count==0: sign-fix and publish result
module mul (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] operand_l,
  input  logic [31:0] operand_r,
  input  logic        lhs_signed,
  input  logic        rhs_signed,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t      state;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [63:0] acc;
  logic [5:0]  count;
  logic        neg;

  logic        l_neg;
  logic        r_neg;
  logic [31:0] mag_l;
  logic [31:0] mag_r;

  always_comb begin
    l_neg = lhs_signed & operand_l[31];
    r_neg = rhs_signed & operand_r[31];
    mag_l = l_neg ? (~operand_l + 32'd1) : operand_l;
    mag_r = r_neg ? (~operand_r + 32'd1) : operand_r;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
      neg       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
    end else begin
      done <= 1'b0;
      // start wins in every state, silently aborting any operation in flight
      if (start) begin
        state  <= ST_RUN;
        mcand  <= {32'd0, mag_l};
        mplier <= mag_r;
        acc    <= '0;
        count  <= 6'd32;
        neg    <= l_neg ^ r_neg;
        busy   <= 1'b1;
      end else if (state == ST_RUN) begin
        if (count != 6'd0) begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= {mcand[62:0], 1'b0};
          mplier <= {1'b0, mplier[31:1]};
          count  <= count - 6'd1;
        end else begin
          {result_hi, result_lo} <= neg ? (~acc + 64'd1) : acc;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul.sv
// Self-checking bench for mul: directed corner cases plus random operands,
// compared against a plain 64-bit arithmetic product model.
module tb_mul;

  logic        clk;
  logic        reset_n;
  logic [31:0] operand_l;
  logic [31:0] operand_r;
  logic        lhs_signed;
  logic        rhs_signed;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;

  int n_checks = 0;
  int n_errors = 0;

  mul dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .operand_l  (operand_l),
    .operand_r  (operand_r),
    .lhs_signed (lhs_signed),
    .rhs_signed (rhs_signed),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .result_lo  (result_lo),
    .result_hi  (result_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] l, input logic [31:0] r,
                                           input logic ls, input logic rs);
    longint a;
    longint b;
    a = ls ? longint'($signed(l)) : longint'({32'd0, l});
    b = rs ? longint'($signed(r)) : longint'({32'd0, r});
    return 64'(a * b);
  endfunction

  // Issue one operation, optionally scrambling the inputs while busy, and check
  // latency, busy duration, result and the single-cycle done pulse.
  task automatic run_op(input logic [31:0] l, input logic [31:0] r,
                        input logic ls, input logic rs, input bit toggle, input string tag);
    logic [63:0] exp;
    int lat;
    int bcnt;
    bit seen;
    exp = ref_prod(l, r, ls, rs);
    @(negedge clk);
    operand_l = l; operand_r = r; lhs_signed = ls; rhs_signed = rs; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bcnt = busy ? 1 : 0;
    lat = 0;
    seen = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      if (toggle) begin
        operand_l = $urandom; operand_r = $urandom;
        lhs_signed = 1'($urandom); rhs_signed = 1'($urandom);
      end
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (done) begin seen = 1; lat = i; end
    end
    check_val({tag, "_latency"}, 64'(lat), 64'd33);
    check_val({tag, "_busy_cycles"}, 64'(bcnt), 64'd33);
    check_val({tag, "_result"}, {result_hi, result_lo}, exp);
    @(posedge clk); #1;
    check_val({tag, "_done_drop"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int dcnt;
    int lat;
    reset_n = 1'b0; start = 1'b0;
    operand_l = '0; operand_r = '0; lhs_signed = 1'b0; rhs_signed = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    #1;
    check_val("reset_outputs", {busy, done, result_hi, result_lo}, 66'd0);

    // Async reset mid-operation discards the work with no done pulse
    @(negedge clk);
    operand_l = 32'd3; operand_r = 32'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_val("reset_mid_busy", {63'd0, busy}, 64'd0);
    check_val("reset_mid_result", {result_hi, result_lo}, 64'd0);
    @(negedge clk) reset_n = 1'b1;
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check_val("reset_no_done", 64'(dcnt), 64'd0);
    check_val("reset_result_held", {result_hi, result_lo}, 64'd0);

    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, "mulhu_max");
    check_val("mulhu_max_lit", {result_hi, result_lo}, 64'hFFFFFFFE_00000001);
    run_op(32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b0, "mulh_min");
    check_val("mulh_min_lit", {result_hi, result_lo}, 64'h40000000_00000000);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, "mulh_m1");
    check_val("mulh_m1_lit", {result_hi, result_lo}, 64'h00000000_00000001);
    run_op(32'd7, 32'hFFFFFFFD, 1'b1, 1'b1, 1'b0, "mulh_7xm3");
    check_val("mulh_7xm3_lit", {result_hi, result_lo}, 64'hFFFFFFFF_FFFFFFEB);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, "mulhsu");
    check_val("mulhsu_lit", {result_hi, result_lo}, 64'hFFFFFFFF_00000001);
    run_op(32'd0, 32'h12345678, 1'b1, 1'b1, 1'b1, "zero_iso");
    check_val("zero_iso_lit", {result_hi, result_lo}, 64'd0);

    // Restart at E5 with new operands: exactly one done, 33 cycles after restart
    @(negedge clk);
    operand_l = 32'd2; operand_r = 32'd3; lhs_signed = 1'b0; rhs_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    dcnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    @(negedge clk);
    operand_l = 32'h10000; operand_r = 32'h10000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk); #1;
      if (done) begin dcnt++; if (lat == 0) lat = i; end
    end
    check_val("restart_done_count", 64'(dcnt), 64'd1);
    check_val("restart_latency", 64'(lat), 64'd33);
    check_val("restart_result", {result_hi, result_lo}, 64'h00000001_00000000);

    // Start presented during the done cycle is accepted
    @(negedge clk);
    operand_l = 32'd6; operand_r = 32'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (done) lat = i;
    end
    check_val("b2b_first_latency", 64'(lat), 64'd33);
    operand_l = 32'hFFFFFFF0; operand_r = 32'd3; lhs_signed = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check_val("b2b_busy_reassert", {63'd0, busy}, 64'd1);
    check_val("b2b_first_result", {result_hi, result_lo}, 64'd54);
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (done) lat = i;
    end
    check_val("b2b_second_latency", 64'(lat), 64'd33);
    check_val("b2b_second_result", {result_hi, result_lo}, 64'hFFFFFFFF_FFFFFFD0);
    lhs_signed = 1'b0;

    for (int k = 0; k < 30; k++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      if (k % 7 == 0) a = 32'h80000000;
      if (k % 11 == 0) b = 32'd0;
      run_op(a, b, 1'($urandom), 1'($urandom), 1'(k % 2), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
